// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : RV32I opcode constants (instr[6:2]) and instruction format
//               codes that are shared by the instruction encoder. Also holds
//               the opcode-to-format lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

  // Major opcodes as they appear in instr[6:2]
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  // Instruction formats
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Any opcode not listed explicitly is packed as an I-type word
  function automatic fmt_e opcode_fmt(input logic [4:0] opcode);
    fmt_e f;
    case (opcode)
      OP_STORE:        f = FMT_S;
      OP_BRANCH:       f = FMT_B;
      OP_LUI, OP_AUIPC: f = FMT_U;
      OP_JAL:          f = FMT_J;
      OP_OP:           f = FMT_R;
      default:         f = FMT_I;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : encoder_fifo2
// Description : Two-entry in-order FIFO with valid/ready on both sides.
//               O_ready is a register (count < 2 after this edge), so there
//               is no combinational path from I_pop to O_ready.
// Revision    : 1.0 - initial release
// Ports       : I_clk, I_reset (sync, active-high)
//               I_push/O_ready/I_data  - write side
//               O_valid/I_pop/O_data   - read side, O_data is the head entry
// ============================================================================
module encoder_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic             I_push,
  output logic             O_ready,
  input  logic [WIDTH-1:0] I_data,
  output logic             O_valid,
  input  logic             I_pop,
  output logic [WIDTH-1:0] O_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  // A push while full is simply refused (ready is low), even when a pop
  // happens in the same cycle.
  assign w_push = I_push && r_ready;
  assign w_pop  = I_pop && (r_count != 2'd0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= I_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign O_ready = r_ready;
  assign O_valid = (r_count != 2'd0);
  assign O_data  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs decoded RV32I fields into a 32-bit instruction word
//               and queues it in a 2-entry output FIFO (latency 1).
// Revision    : 1.0 - initial release
// Options     : ENCODER_IMMCHECK_EN - enables the per-format immediate range
//               check, O_err and the saturating O_errcount. Without it both
//               outputs are tied to 0.
// Ports       : I_clk, I_reset (sync, active-high)
//               I_valid/O_ready + I_opcode,I_rd,I_rs1,I_rs2,I_funct3,
//               I_funct7,I_imm  - decoded fields in
//               O_valid/I_ready + O_instr,O_err - encoded word out
//               O_errcount      - saturating immediate-error count
// ============================================================================
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                I_clk,
  input  logic                I_reset,
  input  logic                I_valid,
  output logic                O_ready,
  input  logic [4:0]          I_opcode,
  input  logic [4:0]          I_rd,
  input  logic [4:0]          I_rs1,
  input  logic [4:0]          I_rs2,
  input  logic [2:0]          I_funct3,
  input  logic [6:0]          I_funct7,
  input  logic [31:0]         I_imm,
  output logic                O_valid,
  input  logic                I_ready,
  output logic [31:0]         O_instr,
  output logic                O_err,
  output logic [ERRCNT_W-1:0] O_errcount
);

  fmt_e        w_fmt;
  logic [31:0] w_instr;
  logic        w_err;
  logic        w_accept;
  logic [32:0] w_head;

  assign w_fmt    = opcode_fmt(I_opcode);
  assign w_accept = I_valid && O_ready;

  // Field packing; immediates are truncated to what the format can carry
  always_comb begin
    w_instr = {I_imm[11:0], I_rs1, I_funct3, I_rd, I_opcode, 2'b11};
    case (w_fmt)
      FMT_R: w_instr = {I_funct7, I_rs2, I_rs1, I_funct3, I_rd, I_opcode, 2'b11};
      FMT_S: w_instr = {I_imm[11:5], I_rs2, I_rs1, I_funct3, I_imm[4:0],
                        I_opcode, 2'b11};
      FMT_B: w_instr = {I_imm[12], I_imm[10:5], I_rs2, I_rs1, I_funct3,
                        I_imm[4:1], I_imm[11], I_opcode, 2'b11};
      FMT_U: w_instr = {I_imm[31:12], I_rd, I_opcode, 2'b11};
      FMT_J: w_instr = {I_imm[20], I_imm[10:1], I_imm[11], I_imm[19:12],
                        I_rd, I_opcode, 2'b11};
      default: w_instr = {I_imm[11:0], I_rs1, I_funct3, I_rd, I_opcode, 2'b11};
    endcase
  end

`ifdef ENCODER_IMMCHECK_EN
  logic [ERRCNT_W-1:0] r_errcount;

  // Immediate must be the sign extension of the bits the format keeps;
  // branch/jump targets must also be 2-byte aligned.
  always_comb begin
    w_err = 1'b0;
    case (w_fmt)
      FMT_R: w_err = 1'b0;
      FMT_B: w_err = (I_imm[31:12] != {20{I_imm[12]}}) || I_imm[0];
      FMT_U: w_err = (I_imm[11:0] != 12'd0);
      FMT_J: w_err = (I_imm[31:20] != {12{I_imm[20]}}) || I_imm[0];
      default: w_err = (I_imm[31:11] != {21{I_imm[11]}});
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_errcount <= '0;
    end else if (w_accept && w_err && (r_errcount != '1)) begin
      r_errcount <= r_errcount + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign O_errcount = r_errcount;
`else
  assign w_err      = 1'b0;
  assign O_errcount = '0;
`endif

  encoder_fifo2 #(
    .WIDTH(33)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_reset (I_reset),
    .I_push  (I_valid),
    .O_ready (O_ready),
    .I_data  ({w_err, w_instr}),
    .O_valid (O_valid),
    .I_pop   (I_ready),
    .O_data  (w_head)
  );

  assign O_instr = w_head[31:0];
  assign O_err   = w_head[32];

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Scoreboard bench for instr_encoder. Stimulus pushes expected
//               words into a queue; a negedge monitor compares the FIFO head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int ERRCNT_W = 8;
  localparam int ERRMAX   = (1 << ERRCNT_W) - 1;
`ifdef ENCODER_IMMCHECK_EN
  localparam bit IMMCHK = 1'b1;
`else
  localparam bit IMMCHK = 1'b0;
`endif

  logic                I_clk = 1'b0;
  logic                I_reset = 1'b1;
  logic                I_valid = 1'b0;
  logic                O_ready;
  logic [4:0]          I_opcode = '0;
  logic [4:0]          I_rd = '0;
  logic [4:0]          I_rs1 = '0;
  logic [4:0]          I_rs2 = '0;
  logic [2:0]          I_funct3 = '0;
  logic [6:0]          I_funct7 = '0;
  logic [31:0]         I_imm = '0;
  logic                O_valid;
  logic                I_ready = 1'b0;
  logic [31:0]         O_instr;
  logic                O_err;
  logic [ERRCNT_W-1:0] O_errcount;

  instr_encoder #(.ERRCNT_W(ERRCNT_W)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_valid(I_valid), .O_ready(O_ready),
    .I_opcode(I_opcode), .I_rd(I_rd), .I_rs1(I_rs1), .I_rs2(I_rs2),
    .I_funct3(I_funct3), .I_funct7(I_funct7), .I_imm(I_imm),
    .O_valid(O_valid), .I_ready(I_ready), .O_instr(O_instr),
    .O_err(O_err), .O_errcount(O_errcount)
  );

  always #5 I_clk = ~I_clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  int   exp_errcnt = 0;
  bit   rnd_mode = 1'b0;
  bit   rdy_cmd = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Consumer ready: either commanded or random; updated at posedge+2
  always @(posedge I_clk) begin
    #2;
    I_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_cmd;
  end

  // Monitor: queue occupancy must match O_valid; head must match O_instr/O_err
  always @(negedge I_clk) begin
    if (mon_en) begin
      chk("valid_vs_queue", O_valid, sb.size() != 0);
      if (O_valid && sb.size() != 0) begin
        chk("instr", O_instr, sb[0].instr);
        chk("err", O_err, sb[0].err);
        if (I_ready) void'(sb.pop_front());
      end
    end
  end

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  // Reference encoding from the ISA field layout and signed-range rules
  function automatic exp_t model(input logic [4:0] op, rd, rs1, rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm);
    exp_t        e;
    longint      s;
    logic [31:0] base;
    s     = longint'($signed(imm));
    base  = 32'd3 | (32'(op) << 2);
    e.err = 1'b0;
    case (op)
      5'h08: begin
        e.instr = base | (fld(imm, 4, 0) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                | (32'(rs2) << 20) | (fld(imm, 11, 5) << 25);
        e.err = (s < -2048) || (s > 2047);
      end
      5'h18: begin
        e.instr = base | (fld(imm, 11, 11) << 7) | (fld(imm, 4, 1) << 8) | (32'(f3) << 12)
                | (32'(rs1) << 15) | (32'(rs2) << 20) | (fld(imm, 10, 5) << 25)
                | (fld(imm, 12, 12) << 31);
        e.err = (s < -4096) || (s > 4095) || (fld(imm, 0, 0) != 0);
      end
      5'h0D, 5'h05: begin
        e.instr = base | (32'(rd) << 7) | (fld(imm, 31, 12) << 12);
        e.err = (fld(imm, 11, 0) != 0);
      end
      5'h1B: begin
        e.instr = base | (32'(rd) << 7) | (fld(imm, 19, 12) << 12) | (fld(imm, 11, 11) << 20)
                | (fld(imm, 10, 1) << 21) | (fld(imm, 20, 20) << 31);
        e.err = (s < -(1 << 20)) || (s >= (1 << 20)) || (fld(imm, 0, 0) != 0);
      end
      5'h0C: begin
        e.instr = base | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                | (32'(rs2) << 20) | (32'(f7) << 25);
      end
      default: begin
        e.instr = base | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                | (fld(imm, 11, 0) << 20);
        e.err = (s < -2048) || (s > 2047);
      end
    endcase
    e.err = e.err & IMMCHK;
    return e;
  endfunction

  // Drive one field set; expectation is queued once the accept edge has passed
  task automatic push(input logic [4:0] op, rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input exp_t e);
    int waitc = 0;
    I_valid = 1'b1; I_opcode = op; I_rd = rd; I_rs1 = rs1; I_rs2 = rs2;
    I_funct3 = f3; I_funct7 = f7; I_imm = imm;
    forever begin
      @(negedge I_clk);
      if (O_ready) break;
      waitc++;
      if (waitc > 200) begin
        total++; bad++;
        $display("FAIL push_timeout: ready=%0b want 1", O_ready);
        break;
      end
    end
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    if (waitc <= 200) begin
      sb.push_back(e);
      if (e.err && exp_errcnt < ERRMAX) exp_errcnt++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge I_clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge I_clk); #1;
  endtask

  task automatic push_rand();
    logic [4:0]  ops [11] = '{5'h00, 5'h03, 5'h04, 5'h05, 5'h08, 5'h0C,
                              5'h0D, 5'h18, 5'h19, 5'h1B, 5'h1C};
    logic [4:0]  op, rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    op  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : ops[$urandom_range(0, 10)];
    rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3  = 3'($urandom); f7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       imm = $urandom;
      default: imm = $urandom << 12;
    endcase
    push(op, rd, rs1, rs2, f3, f7, imm, model(op, rd, rs1, rs2, f3, f7, imm));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time=%0t limit=400000", $time);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge I_clk);
    #1 I_reset = 1'b0;
    @(negedge I_clk);
    chk("rst_valid", O_valid, 0);
    chk("rst_ready", O_ready, 1);
    chk("rst_instr", O_instr, 0);
    chk("rst_err", O_err, 0);
    chk("rst_errcount", O_errcount, 0);
    mon_en = 1'b1;
    @(posedge I_clk); #1;
    rdy_cmd = 1'b1;
    @(posedge I_clk); #1;

    // Directed words; first one also checks latency 1
    push(5'h04, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, '{instr: 32'h00500093, err: 1'b0});
    @(negedge I_clk);
    chk("lat1_valid", O_valid, 1);
    chk("lat1_instr", O_instr, 32'h00500093);
    @(posedge I_clk); #1;
    push(5'h08, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, '{instr: 32'h0020A423, err: 1'b0});
    push(5'h1B, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, '{instr: 32'h001000EF, err: 1'b0});
    push(5'h18, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, '{instr: 32'hFE000EE3, err: 1'b0});
    push(5'h04, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, '{instr: 32'h80000093, err: IMMCHK});
    drain();
    chk("errcount_directed", O_errcount, exp_errcnt);

    // Backpressure: two accepted, third held until a pop
    rdy_cmd = 1'b0;
    repeat (2) @(posedge I_clk); #1;
    push(5'h04, 5'd2, 5'd3, 5'd0, 3'd1, 7'd0, 32'd1, '{instr: 32'h00119113, err: 1'b0});
    push(5'h04, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, 32'd2, '{instr: 32'h00220193, err: 1'b0});
    @(negedge I_clk);
    chk("full_ready", O_ready, 0);
    @(posedge I_clk); #1;
    fork
      push(5'h0C, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0, '{instr: 32'h407302B3, err: 1'b0});
      begin
        repeat (3) begin
          @(negedge I_clk);
          chk("held_ready", O_ready, 0);
        end
        @(posedge I_clk); #1;
        rdy_cmd = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random consumer stalls
    rnd_mode = 1'b1;
    repeat (300) push_rand();
    rnd_mode = 1'b0;
    rdy_cmd  = 1'b1;
    repeat (2) @(posedge I_clk); #1;
    drain();
    chk("errcount_random", O_errcount, exp_errcnt);

`ifdef ENCODER_IMMCHECK_EN
    // Saturation of the error counter
    repeat (ERRMAX + 5)
      push(5'h04, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, '{instr: 32'h80000093, err: 1'b1});
    drain();
    chk("errcount_sat", O_errcount, ERRMAX);
`endif

    // Reset with two words queued
    rdy_cmd = 1'b0;
    repeat (2) @(posedge I_clk); #1;
    push(5'h0D, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, '{instr: 32'h123454B7, err: 1'b0});
    push(5'h05, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, '{instr: 32'hABCDE497, err: 1'b0});
    @(negedge I_clk);
    chk("pre_rst_ready", O_ready, 0);
    @(posedge I_clk); #1;
    I_reset = 1'b1; mon_en = 1'b0;
    sb.delete();
    exp_errcnt = 0;
    @(posedge I_clk); #1;
    I_reset = 1'b0;
    @(negedge I_clk);
    chk("mid_rst_valid", O_valid, 0);
    chk("mid_rst_ready", O_ready, 1);
    chk("mid_rst_instr", O_instr, 0);
    chk("mid_rst_errcount", O_errcount, 0);
    mon_en = 1'b1;
    @(posedge I_clk); #1;
    rdy_cmd = 1'b1;
    @(posedge I_clk); #1;
    push(5'h19, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, '{instr: 32'hFFF100E7, err: 1'b0});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Inverse of the CPU instruction decoder. Accepts decoded RISC-V RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs them into a 32-bit instruction word. Words go through a 2-entry output FIFO with an independent valid/ready handshake. Used by the debug/boot instruction injector and the self-test sequencer to feed synthesized instructions to the fetch path.

Parameters:
ERRCNT_W, 8, width of saturating immediate-error counter (used only with the optional feature)

Ports:
I_clk  in  1  clock, all state on rising edge
I_reset  in  1  synchronous reset, active-high
I_valid  in  1  input fields valid
O_ready  out  1  encoder can accept fields (registered, = FIFO not full)
I_opcode  in  5  instr[6:2]
I_rd  in  5  destination register
I_rs1  in  5  source register 1
I_rs2  in  5  source register 2
I_funct3  in  3  funct3
I_funct7  in  7  funct7 (R-type only)
I_imm  in  32  sign-extended immediate, same layout the decoder produces
O_valid  out  1  O_instr valid
I_ready  in  1  consumer takes word
O_instr  out  32  encoded instruction
O_err  out  1  immediate not representable for this word (0 without feature)
O_errcount  out  ERRCNT_W  saturating error count (0 without feature)

Behaviour:
- Reset: FIFO count 0, O_valid=0, O_ready=1, O_instr=0, O_err=0, O_errcount=0. Reset mid-operation discards all entries; no word emitted after reset edge.
- Accept when I_valid && O_ready at rising edge; word visible on O_instr with O_valid=1 after that same edge (latency 1). Pop when O_valid && I_ready.
- instr[1:0]=2'b11 always. Format by opcode: OP_STORE S; OP_BRANCH B; OP_LUI/OP_AUIPC U (instr[31:12]=imm[31:12]); OP_JAL J; OP_OP R (funct7, rs2, rs1, funct3, rd); all others I (instr[31:20]=imm[11:0]). Shift-immediates: caller places funct7 in imm[11:5]. Fields not used by the format are ignored.
- FIFO: 2 entries, in-order. O_ready = count<2, registered; no combinational path from I_ready to O_ready. Full + pop + I_valid: pop occurs, push refused that cycle. count=1 + push + pop: count stays 1, order kept. Empty: pop ignored, O_valid=0.
- O_instr/O_err hold the head entry; stable while O_valid && !I_ready.

Optional Feature:
ENCODER_IMMCHECK_EN. With it: range check per format, I/S imm must equal sext(imm[11:0]); B sext(imm[12:0]) and imm[0]=0; J sext(imm[20:0]) and imm[0]=0; U imm[11:0]=0; R never errs. Failing word is still encoded (truncated), stored with err=1; O_errcount increments at acceptance, saturates at all-ones, cleared only by reset. Without it: O_err and O_errcount tied 0, no check logic.

Decomposition:
- Add format codes FMT_R/I/S/B/U/J to the shared riscvdefs.vh next to existing OP_* and FUNC_* constants; encoder uses OP_* from there.
- One sub-module: encoder_fifo2 (2-entry FIFO, width 33 = instr + err, registered ready). Format selection and packing stay in instr_encoder.

Test Plan:
- OP_IMM rd=1 rs1=0 f3=0 imm=5 -> O_instr=0x00500093 one cycle after accept, O_err=0.
- OP_STORE rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423; OP_JAL rd=1 imm=0x800 -> 0x001000EF.
- OP_BRANCH rs1=0 rs2=0 f3=0 imm=0xFFFFFFFC -> 0xFE000EE3.
- I_ready=0, push 3 words back-to-back -> O_ready=0 after 2nd accept, 3rd held; raise I_ready -> words out in order, O_ready=1 after first pop.
- With ENCODER_IMMCHECK_EN: OP_IMM rd=1 imm=0x800 -> 0x80000093, O_err=1, O_errcount=1; 256 errors with ERRCNT_W=8 -> count stays 255. Without macro: O_err=0, O_errcount=0.
- Assert I_reset with 2 words queued -> next cycle O_valid=0, O_ready=1, count 0.
